// File: rtl/la_scanctrl_pkg.sv
// Shared types for the scan-chain driver: FSM state encoding.
package la_scanctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CAPTURE,
      S_UNLOAD,
      S_DONE
   } scan_state_t;

endpackage

// File: rtl/la_scanshift.sv
// N-bit shift register with parallel load, MSB-ward serial shift-in from the LSB,
// and parallel out (MSB doubles as serial out).
module la_scanshift #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         nreset,
   input  logic         load,
   input  logic [N-1:0] pdata,
   input  logic         shift,
   input  logic         sin,
   output logic [N-1:0] q
);

   logic [N-1:0] shifted;

   // A one-bit register has no upper bits to keep, so a shift is a plain load of sin.
   if (N == 1) begin : g_one
      assign shifted = sin;
   end else begin : g_many
      assign shifted = {q[N-2:0], sin};
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         q <= '0;
      end else if (load) begin
         q <= pdata;
      end else if (shift) begin
         q <= shifted;
      end
   end

endmodule

// File: rtl/la_scanctrl.sv
// Scan-chain driver: loads a parallel pattern into an external N-flop chain,
// pulses one capture cycle, then unloads and presents the captured response.
module la_scanctrl
   import la_scanctrl_pkg::*;
#(
   parameter int unsigned N    = 8,
   parameter string       PROP = "DEFAULT"
) (
   input  logic         clk,
   input  logic         nreset,
   input  logic         start,
   input  logic [N-1:0] pattern,
   output logic         ready,
   output logic         se,
   output logic         si,
   input  logic         so,
   output logic         done,
   output logic [N-1:0] response
);

   localparam int unsigned CW = $clog2(N + 1);

   scan_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tx_load, tx_shift, rx_shift;
   logic [N-1:0]  tx_q;
   logic          ready_q, se_q, done_q;
   logic          unused_ok;

   // tx shifts zeros in behind the pattern, so si falls to 0 on its own after LOAD.
   la_scanshift #(.N(N)) u_tx (
      .clk    (clk),
      .nreset (nreset),
      .load   (tx_load),
      .pdata  (pattern),
      .shift  (tx_shift),
      .sin    (1'b0),
      .q      (tx_q)
   );

   la_scanshift #(.N(N)) u_rx (
      .clk    (clk),
      .nreset (nreset),
      .load   (1'b0),
      .pdata  ('0),
      .shift  (rx_shift),
      .sin    (so),
      .q      (response)
   );

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tx_load  = 1'b0;
      tx_shift = 1'b0;
      rx_shift = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               cnt_d   = CW'(N);
               tx_load = 1'b1;
            end
         end
         S_LOAD: begin
            tx_shift = 1'b1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            cnt_d   = CW'(N);
            state_d = S_UNLOAD;
         end
         S_UNLOAD: begin
            rx_shift = 1'b1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the state itself.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         ready_q <= 1'b1;
         se_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         ready_q <= (state_d == S_IDLE);
         se_q    <= (state_d == S_LOAD) || (state_d == S_UNLOAD);
         done_q  <= (state_d == S_DONE);
      end
   end

   assign ready = ready_q;
   assign se    = se_q;
   assign done  = done_q;
   assign si    = tx_q[N-1];

   assign unused_ok = (PROP != "") ^ (^tx_q);

endmodule

// File: tb/tb_la_scanctrl.sv
// Bench for la_scanctrl: behavioural scan chains for N=8 and N=1, response scoreboard.
module tb_la_scanctrl;

   logic       clk = 1'b0;
   logic       nreset;
   logic       start8, start1;
   logic [7:0] pattern8;
   logic [0:0] pattern1;
   logic       ready8, se8, si8, so8, done8;
   logic [7:0] response8;
   logic       ready1, se1, si1, so1, done1;
   logic [0:0] response1;

   logic [7:0] ch8;
   logic       ch1;
   logic       constd = 1'b0;

   int errors = 0;
   int checks = 0;
   logic [7:0] sb8[$];
   logic       sb1[$];

   always #5 clk = ~clk;

   la_scanctrl #(.N(8)) u_dut8 (
      .clk      (clk),
      .nreset   (nreset),
      .start    (start8),
      .pattern  (pattern8),
      .ready    (ready8),
      .se       (se8),
      .si       (si8),
      .so       (so8),
      .done     (done8),
      .response (response8)
   );

   la_scanctrl #(.N(1)) u_dut1 (
      .clk      (clk),
      .nreset   (nreset),
      .start    (start1),
      .pattern  (pattern1),
      .ready    (ready1),
      .se       (se1),
      .si       (si1),
      .so       (so1),
      .done     (done1),
      .response (response1)
   );

   // Chain model: flop 0 fed by si, flop N-1 drives so; capture d is ~q or 8'h3C.
   always @(posedge clk) begin
      if (se8) ch8 <= {ch8[6:0], si8};
      else     ch8 <= constd ? 8'h3C : ~ch8;
   end
   assign so8 = ch8[7];

   always @(posedge clk) ch1 <= se1 ? si1 : ~ch1;
   assign so1 = ch1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (nreset && done8) begin
         check("sb8_pending", 32'(sb8.size() != 0), 1);
         if (sb8.size() != 0) check("resp8", response8, sb8.pop_front());
      end
      if (nreset && done1) begin
         check("sb1_pending", 32'(sb1.size() != 0), 1);
         if (sb1.size() != 0) check("resp1", response1, sb1.pop_front());
      end
   end

   task automatic run8(input logic [7:0] pat, input logic cd);
      logic [7:0] exp;
      exp = cd ? 8'h3C : ~pat;
      @(negedge clk);
      constd   = cd;
      pattern8 = pat;
      start8   = 1'b1;
      check("ready8_idle", ready8, 1);
      @(posedge clk);
      #1;
      start8   = 1'b0;
      pattern8 = ~pat;
      sb8.push_back(exp);
      for (int c = 1; c <= 19; c++) begin
         @(negedge clk);
         check($sformatf("se8_c%0d", c), se8, 32'((c <= 8) || (c >= 10 && c <= 17)));
         check($sformatf("si8_c%0d", c), si8, 32'((c <= 8) ? pat[8-c] : 1'b0));
         check($sformatf("done8_c%0d", c), done8, 32'(c == 18));
         check($sformatf("ready8_c%0d", c), ready8, 32'(c == 19));
      end
   endtask

   task automatic run1(input logic pat);
      @(negedge clk);
      pattern1 = pat;
      start1   = 1'b1;
      check("ready1_idle", ready1, 1);
      @(posedge clk);
      #1;
      start1 = 1'b0;
      sb1.push_back(~pat);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         check($sformatf("se1_c%0d", c), se1, 32'(c == 1 || c == 3));
         check($sformatf("si1_c%0d", c), si1, 32'((c == 1) ? pat : 1'b0));
         check($sformatf("done1_c%0d", c), done1, 32'(c == 4));
         check($sformatf("ready1_c%0d", c), ready1, 32'(c == 5));
      end
   endtask

   initial begin
      int acc;
      nreset   = 1'b0;
      start8   = 1'b0;
      start1   = 1'b0;
      pattern8 = '0;
      pattern1 = '0;
      repeat (2) @(negedge clk);
      check("rst_ready8", ready8, 1);
      check("rst_se8", se8, 0);
      check("rst_si8", si8, 0);
      check("rst_done8", done8, 0);
      check("rst_resp8", response8, 0);
      check("rst_ready1", ready1, 1);
      check("rst_se1", se1, 0);
      nreset = 1'b1;

      run8(8'hA5, 1'b0);
      run8(8'h33, 1'b1);

      // start held high: one acceptance every 19 cycles
      @(negedge clk);
      constd   = 1'b0;
      pattern8 = 8'hA5;
      start8   = 1'b1;
      acc      = 0;
      for (int i = 0; i < 57; i++) begin
         if (i > 0) @(negedge clk);
         if (ready8) begin
            check("acc_slot", i % 19, 0);
            acc++;
            sb8.push_back(8'h5A);
         end
      end
      start8 = 1'b0;
      check("acc_count", acc, 3);

      // asynchronous reset in the middle of UNLOAD
      @(negedge clk);
      pattern8 = 8'hA5;
      start8   = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      repeat (12) @(negedge clk);
      check("se8_unload", se8, 1);
      check("resp8_partial_nz", 32'(response8 != 8'h00), 1);
      #1;
      nreset = 1'b0;
      #1;
      check("arst_se8", se8, 0);
      check("arst_si8", si8, 0);
      check("arst_done8", done8, 0);
      check("arst_resp8", response8, 0);
      check("arst_ready8", ready8, 1);
      sb8.delete();
      @(negedge clk);
      nreset = 1'b1;
      run8(8'hFF, 1'b0);
      run8(8'h00, 1'b0);

      run1(1'b1);
      run1(1'b0);

      repeat (2) @(negedge clk);
      check("sb8_drained", sb8.size(), 0);
      check("sb1_drained", sb1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
